// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and default sizes for the resource cover arbiter
package arb_pkg;

    localparam int DEF_NREQ = 4;
    localparam int DEF_NRES = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } req_state_t;

endpackage

// File: rtl/mask_cover.sv
// rtl/mask_cover.sv - checks whether a needed resource set is fully available
module mask_cover
    import arb_pkg::*;
#(
    parameter int NRES = DEF_NRES
) (
    input  logic [NRES-1:0] need,
    input  logic [NRES-1:0] avail,
    output logic            ok,
    output logic [NRES-1:0] fit
);

    // An empty request never counts as covered; otherwise every needed bit must be free
    assign ok  = (|need) && ((need & ~avail) == '0);
    assign fit = need & avail;

endmodule

// File: rtl/resource_cover_arbiter.sv
// rtl/resource_cover_arbiter.sv - round-robin arbiter granting whole resource sets
module resource_cover_arbiter
    import arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int NRES = DEF_NRES
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*NRES-1:0] req_mask,
    input  logic [NREQ-1:0]      rel,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ*NRES-1:0] held,
    output logic [NRES-1:0]      free_mask,
    output logic [NREQ-1:0]      err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    req_state_t           state_q [NREQ];
    req_state_t           state_d [NREQ];
    logic [PW-1:0]        rr_ptr_q;
    logic [PW-1:0]        rr_ptr_d;
    logic [NREQ-1:0]      cover_ok;
    logic [NRES-1:0]      cover_fit [NREQ];
    logic [NREQ-1:0]      eligible;
    logic                 win_valid;
    logic [PW-1:0]        win_idx;
    logic [NREQ-1:0]      grant_d;
    logic [NREQ-1:0]      err_d;
    logic [NREQ*NRES-1:0] held_d;
    logic [NRES-1:0]      busy_d;

    // Coverage is judged against the registered free mask, so bits freed this
    // cycle only become grantable on the following evaluation.
    for (genvar g = 0; g < NREQ; g++) begin : g_cover
        mask_cover #(.NRES(NRES)) u_cover (
            .need  (req_mask[g*NRES +: NRES]),
            .avail (free_mask),
            .ok    (cover_ok[g]),
            .fit   (cover_fit[g])
        );
        assign eligible[g] = (state_q[g] == WAIT) && req[g] && cover_ok[g];
    end

    // Rotating-priority pick: first eligible requester at or after rr_ptr
    always_comb begin : p_pick
        logic [PW-1:0] idx;
        win_valid = 1'b0;
        win_idx   = '0;
        idx       = '0;
        for (int off = 0; off < NREQ; off++) begin
            idx = PW'((int'(rr_ptr_q) + off) % NREQ);
            if (!win_valid && eligible[idx]) begin
                win_valid = 1'b1;
                win_idx   = idx;
            end
        end
    end

    // Pointer moves just past the winner so it gets lowest priority next time
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        grant_d  = '0;
        if (win_valid) begin
            rr_ptr_d = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
            grant_d  = NREQ'(1) << win_idx;
        end
    end

    // Per-requester FSM transitions, ownership updates and error detection
    always_comb begin
        err_d  = '0;
        held_d = held;
        for (int i = 0; i < NREQ; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                IDLE: begin
                    if (req[i]) begin
                        if (|req_mask[i*NRES +: NRES]) state_d[i] = WAIT;
                        else                           err_d[i]   = 1'b1;
                    end
                end
                WAIT: begin
                    if (!req[i]) begin
                        state_d[i] = IDLE;
                    end else if (win_valid && (win_idx == PW'(i))) begin
                        state_d[i]                = HOLD;
                        held_d[i*NRES +: NRES]    = cover_fit[i];
                    end
                end
                HOLD: begin
                    if (rel[i]) begin
                        state_d[i]             = IDLE;
                        held_d[i*NRES +: NRES] = '0;
                    end
                end
                default: state_d[i] = IDLE;
            endcase
            if (rel[i] && (state_q[i] != HOLD)) err_d[i] = 1'b1;
        end
    end

    // Free mask is derived from the next ownership so it always matches held
    always_comb begin
        busy_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            busy_d = busy_d | held_d[i*NRES +: NRES];
        end
    end

    // State, pointer and all registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREQ; i++) state_q[i] <= IDLE;
            rr_ptr_q  <= '0;
            grant     <= '0;
            err       <= '0;
            held      <= '0;
            free_mask <= '1;
        end else begin
            for (int i = 0; i < NREQ; i++) state_q[i] <= state_d[i];
            rr_ptr_q  <= rr_ptr_d;
            grant     <= grant_d;
            err       <= err_d;
            held      <= held_d;
            free_mask <= ~busy_d;
        end
    end

endmodule

// File: tb/tb_resource_cover_arbiter.sv
// tb/tb_resource_cover_arbiter.sv - self-checking bench for resource_cover_arbiter
module tb_resource_cover_arbiter;

    localparam int NREQ = 4;
    localparam int NRES = 6;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ*NRES-1:0] req_mask = '0;
    logic [NREQ-1:0]      rel = '0;
    logic [NREQ-1:0]      grant;
    logic [NREQ*NRES-1:0] held;
    logic [NRES-1:0]      free_mask;
    logic [NREQ-1:0]      err;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: who waits, who owns what, next-in-line pointer
    bit [NRES-1:0]   m_own  [NREQ];
    bit              m_wait [NREQ];
    bit              m_hold [NREQ];
    int              m_rr;
    logic [NREQ-1:0] m_grant;
    logic [NREQ-1:0] m_err;
    logic [NRES-1:0] m_free;

    resource_cover_arbiter #(.NREQ(NREQ), .NRES(NRES)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .req_mask  (req_mask),
        .rel       (rel),
        .grant     (grant),
        .held      (held),
        .free_mask (free_mask),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < NREQ; i++) begin
            m_own[i]  = '0;
            m_wait[i] = 1'b0;
            m_hold[i] = 1'b0;
        end
        m_rr    = 0;
        m_grant = '0;
        m_err   = '0;
        m_free  = '1;
    endtask

    task automatic model_step();
        int win;
        bit [NRES-1:0] mi;
        bit [NRES-1:0] busy;
        win = -1;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j  = (m_rr + k) % NREQ;
            mi = req_mask[j*NRES +: NRES];
            if (win < 0 && m_wait[j] && req[j] && mi != 0 && (mi & ~m_free) == 0) win = j;
        end
        m_err = '0;
        for (int i = 0; i < NREQ; i++) begin
            mi = req_mask[i*NRES +: NRES];
            if (rel[i] && !m_hold[i]) m_err[i] = 1'b1;
            if (m_hold[i]) begin
                if (rel[i]) begin
                    m_hold[i] = 1'b0;
                    m_own[i]  = '0;
                end
            end else if (m_wait[i]) begin
                if (!req[i]) begin
                    m_wait[i] = 1'b0;
                end else if (i == win) begin
                    m_wait[i] = 1'b0;
                    m_hold[i] = 1'b1;
                    m_own[i]  = mi;
                end
            end else if (req[i]) begin
                if (mi == 0) m_err[i]  = 1'b1;
                else         m_wait[i] = 1'b1;
            end
        end
        m_grant = '0;
        if (win >= 0) begin
            m_grant[win] = 1'b1;
            m_rr = (win + 1) % NREQ;
        end
        busy = '0;
        for (int i = 0; i < NREQ; i++) busy |= m_own[i];
        m_free = ~busy;
    endtask

    // one clock edge: model follows the same inputs, then land on the falling edge
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        req      = '0;
        rel      = '0;
        req_mask = '0;
        repeat (2) @(negedge clk);
        model_reset();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        req = '0; rel = '0; req_mask = '0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        n_checks++;
        if (free_mask !== 6'b111111) begin
            n_errors++; $display("FAIL reset_free: got %b expected 111111", free_mask);
        end
        n_checks++;
        if (held !== '0) begin
            n_errors++; $display("FAIL reset_held: got %h expected 0", held);
        end
        n_checks++;
        if (grant !== 4'b0000 || err !== 4'b0000) begin
            n_errors++; $display("FAIL reset_grant_err: got %b/%b expected 0000/0000", grant, err);
        end
        reset_n = 1'b1;
        req[0] = 1'b1; req_mask[0 +: 6] = 6'b110000;
        step();
        n_checks++;
        if (grant !== 4'b0000) begin
            n_errors++; $display("FAIL t1_early_grant: got %b expected 0000", grant);
        end
        step();
        req[0] = 1'b0;
        n_checks++;
        if (grant !== 4'b0001) begin
            n_errors++; $display("FAIL t1_grant: got %b expected 0001", grant);
        end
        n_checks++;
        if (free_mask !== 6'b001111 || held[0 +: 6] !== 6'b110000) begin
            n_errors++; $display("FAIL t1_owner: got free %b held0 %b expected 001111 110000", free_mask, held[0 +: 6]);
        end
    endtask

    task automatic test_conflict();
        req[1] = 1'b1; req_mask[6 +: 6] = 6'b100100;
        step();
        step();
        n_checks++;
        if (grant !== 4'b0000) begin
            n_errors++; $display("FAIL t2_blocked: got %b expected 0000", grant);
        end
        rel[0] = 1'b1;
        step();
        rel[0] = 1'b0;
        n_checks++;
        if (grant !== 4'b0000 || free_mask !== 6'b111111) begin
            n_errors++; $display("FAIL t2_release: got grant %b free %b expected 0000 111111", grant, free_mask);
        end
        step();
        req[1] = 1'b0;
        n_checks++;
        if (grant !== 4'b0010 || free_mask !== 6'b011011) begin
            n_errors++; $display("FAIL t2_grant: got grant %b free %b expected 0010 011011", grant, free_mask);
        end
        rel[1] = 1'b1;
        step();
        rel[1] = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] exp_g;
        do_reset();
        req_mask = {6'b001000, 6'b000100, 6'b000010, 6'b000001};
        req = 4'b1111;
        step();
        for (int k = 0; k < NREQ; k++) begin
            step();
            exp_g = NREQ'(1) << k;
            n_checks++;
            if (grant !== exp_g) begin
                n_errors++; $display("FAIL t3_rr_%0d: got %b expected %b", k, grant, exp_g);
            end
            req = req & ~exp_g;
        end
        rel = 4'b1111;
        step();
        rel = '0;
        n_checks++;
        if (err !== 4'b0000 || free_mask !== 6'b111111) begin
            n_errors++; $display("FAIL t3_release: got err %b free %b expected 0000 111111", err, free_mask);
        end
    endtask

    task automatic test_zero_mask();
        req[2] = 1'b1; req_mask[12 +: 6] = 6'b000000;
        step();
        req[2] = 1'b0;
        n_checks++;
        if (err !== 4'b0100 || grant !== 4'b0000) begin
            n_errors++; $display("FAIL t4_zero: got err %b grant %b expected 0100 0000", err, grant);
        end
        step();
        n_checks++;
        if (err !== 4'b0000) begin
            n_errors++; $display("FAIL t4_err_pulse: got %b expected 0000", err);
        end
        rel[3] = 1'b1;
        step();
        rel[3] = 1'b0;
        n_checks++;
        if (err !== 4'b1000) begin
            n_errors++; $display("FAIL t4_rel_idle: got %b expected 1000", err);
        end
        step();
    endtask

    task automatic test_same_cycle_rel();
        req[0] = 1'b1; req_mask[0 +: 6] = 6'b111010;
        step();
        step();
        req[0] = 1'b0;
        req[1] = 1'b1; req_mask[6 +: 6] = 6'b110111;
        step();
        step();
        n_checks++;
        if (grant !== 4'b0000) begin
            n_errors++; $display("FAIL t5_blocked: got %b expected 0000", grant);
        end
        rel[0] = 1'b1;
        step();
        rel[0] = 1'b0;
        n_checks++;
        if (grant !== 4'b0000) begin
            n_errors++; $display("FAIL t5_no_reuse: got %b expected 0000", grant);
        end
        step();
        req[1] = 1'b0;
        n_checks++;
        if (grant !== 4'b0010 || held[6 +: 6] !== 6'b110111) begin
            n_errors++; $display("FAIL t5_grant: got grant %b held1 %b expected 0010 110111", grant, held[6 +: 6]);
        end
    endtask

    task automatic test_async_reset();
        req[0] = 1'b1; req_mask[0 +: 6] = 6'b001000;
        step();
        step();
        req[0] = 1'b0;
        n_checks++;
        if (free_mask !== 6'b000000) begin
            n_errors++; $display("FAIL t6_both_hold: got free %b expected 000000", free_mask);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (held !== '0 || free_mask !== 6'b111111) begin
            n_errors++; $display("FAIL t6_async: got held %h free %b expected 0 111111", held, free_mask);
        end
        req = '0; rel = '0; req_mask = '0;
        repeat (2) @(negedge clk);
        model_reset();
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (grant !== 4'b0000) begin
                n_errors++; $display("FAIL t6_release_%0d: got %b expected 0000", k, grant);
            end
        end
    endtask

    task automatic test_random();
        logic [NREQ*NRES-1:0] exp_held;
        logic [NRES-1:0] m;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                rel[i] = 1'b0;
                if (m_hold[i]) begin
                    req[i] = 1'b0;
                    rel[i] = ($urandom_range(0, 5) == 0);
                end else if (m_wait[i]) begin
                    if ($urandom_range(0, 30) == 0) req[i] = 1'b0;
                    rel[i] = ($urandom_range(0, 40) == 0);
                end else begin
                    if (req[i]) begin
                        req[i] = 1'b0;
                    end else if ($urandom_range(0, 2) == 0) begin
                        m = NRES'($urandom_range(0, 63)) & NRES'($urandom_range(0, 63));
                        req_mask[i*NRES +: NRES] = m;
                        req[i] = 1'b1;
                    end
                    if ($urandom_range(0, 40) == 0) rel[i] = 1'b1;
                end
            end
            step();
            for (int i = 0; i < NREQ; i++) exp_held[i*NRES +: NRES] = m_own[i];
            n_checks++;
            if (grant !== m_grant) begin
                n_errors++; $display("FAIL rnd_grant cyc %0d: got %b expected %b", cyc, grant, m_grant);
            end
            n_checks++;
            if (err !== m_err) begin
                n_errors++; $display("FAIL rnd_err cyc %0d: got %b expected %b", cyc, err, m_err);
            end
            n_checks++;
            if (held !== exp_held) begin
                n_errors++; $display("FAIL rnd_held cyc %0d: got %h expected %h", cyc, held, exp_held);
            end
            n_checks++;
            if (free_mask !== m_free) begin
                n_errors++; $display("FAIL rnd_free cyc %0d: got %b expected %b", cyc, free_mask, m_free);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_conflict();
        test_round_robin();
        test_zero_mask();
        test_same_cycle_rel();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
